// File: rtl/mult_div_unit_pkg.sv
// rtl/mult_div_unit_pkg.sv - op codes, FSM states and decode helper for the HI/LO multiply/divide unit
// Ports: none (package).
package mult_div_unit_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } mdu_state_e;

    // Ops that run for a multi-cycle window and commit through the staging registers.
    function automatic logic is_long_op(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - EX-stage to multiply/divide unit issue and result bundle
// Signals: start, op[2:0], A[31:0], B[31:0] (EX -> unit); busy, HI[31:0], LO[31:0] (unit -> EX/hazard).
interface mult_div_unit_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (output start, op, A, B, input busy, HI, LO);
    modport slave  (input start, op, A, B, output busy, HI, LO);
endinterface

// File: rtl/mdu_core.sv
// rtl/mdu_core.sv - combinational multiply/divide datapath producing HI/LO results
// Ports: op[2:0], A[31:0], B[31:0] in; res_hi[31:0], res_lo[31:0] out.
module mdu_core
    import mult_div_unit_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q_u;
    logic [31:0] r_u;
    logic        div_zero;

    always_comb begin
        // Low 64 bits of the product of sign-extended operands is the signed product.
        prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        prod_u = {32'b0, A} * {32'b0, B};

        // Signed divide on magnitudes: keeps 0x80000000 / -1 well defined (magnitude 2^31
        // fits unsigned) and avoids relying on the host's signed-overflow behaviour.
        mag_a    = A[31] ? (~A + 32'd1) : A;
        mag_b    = B[31] ? (~B + 32'd1) : B;
        div_zero = (B == 32'd0);
        q_mag    = div_zero ? 32'd0 : (mag_a / mag_b);
        r_mag    = div_zero ? 32'd0 : (mag_a % mag_b);
        q_u      = div_zero ? 32'd0 : (A / B);
        r_u      = div_zero ? 32'd0 : (A % B);

        res_hi = 32'd0;
        res_lo = 32'd0;
        case (op)
            MDU_MULT:  {res_hi, res_lo} = prod_s;
            MDU_MULTU: {res_hi, res_lo} = prod_u;
            MDU_DIV: begin
                if (div_zero) begin
                    res_hi = A;
                    res_lo = 32'hFFFF_FFFF;
                end else begin
                    res_lo = (A[31] ^ B[31]) ? (~q_mag + 32'd1) : q_mag;
                    res_hi = A[31] ? (~r_mag + 32'd1) : r_mag;
                end
            end
            MDU_DIVU: begin
                if (div_zero) begin
                    res_hi = A;
                    res_lo = 32'hFFFF_FFFF;
                end else begin
                    res_hi = r_u;
                    res_lo = q_u;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - HI/LO multiply/divide unit: IDLE/BUSY FSM, latency counter, staging and HI/LO
// Ports: clk, reset_n (async active-low), mdu (slave: start, op, A, B in; busy, HI, LO out).
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic            clk,
    input  logic            reset_n,
    mult_div_unit_if.slave  mdu
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      stage_hi_q, stage_hi_d;
    logic [31:0]      stage_lo_q, stage_lo_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      res_hi;
    logic [31:0]      res_lo;

    mdu_core u_core (
        .op     (mdu.op),
        .A      (mdu.A),
        .B      (mdu.B),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            stage_hi_q <= '0;
            stage_lo_q <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            stage_hi_q <= stage_hi_d;
            stage_lo_q <= stage_lo_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stage_hi_d = stage_hi_q;
        stage_lo_d = stage_lo_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        case (state_q)
            S_IDLE: begin
                if (mdu.start) begin
                    if (is_long_op(mdu.op)) begin
                        // Result is captured now; the window only models latency.
                        stage_hi_d = res_hi;
                        stage_lo_d = res_lo;
                        cnt_d      = is_div_op(mdu.op) ? CNT_W'(DIV_CYCLES - 1)
                                                       : CNT_W'(MULT_CYCLES - 1);
                        state_d    = S_BUSY;
                    end else if (mdu.op == MDU_MTHI) begin
                        hi_d = mdu.A;
                    end else if (mdu.op == MDU_MTLO) begin
                        lo_d = mdu.A;
                    end
                end
            end
            S_BUSY: begin
                // start is deliberately not looked at here: issues while busy are dropped.
                if (cnt_q == '0) begin
                    hi_d    = stage_hi_q;
                    lo_d    = stage_lo_q;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mdu.busy = (state_q == S_BUSY);
    assign mdu.HI   = hi_q;
    assign mdu.LO   = lo_q;

endmodule
